// File: rtl/uart_pkg.sv
// Shared constants, sequencer state encoding and baud divisor helper
// for the UART message transmitter.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // start + 8 data + parity + 2 stop
  localparam int FRAME_MAX_BITS = 12;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FRAME = 2'd1;
  localparam state_t ST_GAP   = 2'd2;

  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// Single-frame UART serializer: accepts a byte on valid&&ready and shifts out
// start, data (LSB first), optional parity and stop bits, each DIV cycles long.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DIV       = 10,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       last_cycle,
  output logic       tx
);

  localparam int NBITS = 1 + DATA_BITS + ((PARITY != PARITY_NONE) ? 1 : 0) + STOP_BITS;
  localparam int BW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(NBITS - 1);
  localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);

  logic                      active_reg;
  logic                      tx_reg;
  logic [BW-1:0]             baud_cnt_reg;
  logic [3:0]                bit_cnt_reg;
  logic [FRAME_MAX_BITS-2:0] shift_reg;
  logic [FRAME_MAX_BITS-1:0] frame_bits;
  logic                      parity_bit;
  logic                      load;

  assign parity_bit = (^(data & DATA_MASK)) ^ (PARITY == PARITY_ODD);

  // Whole frame laid out LSB-first; everything past the parity slot idles high,
  // which also provides the stop bits.
  for (genvar gi = 0; gi < FRAME_MAX_BITS; gi++) begin : g_frame
    if (gi == 0) begin : g_start
      assign frame_bits[gi] = 1'b0;
    end else if (gi <= DATA_BITS) begin : g_data
      assign frame_bits[gi] = data[gi-1];
    end else if ((gi == DATA_BITS + 1) && (PARITY != PARITY_NONE)) begin : g_par
      assign frame_bits[gi] = parity_bit;
    end else begin : g_stop
      assign frame_bits[gi] = 1'b1;
    end
  end

  assign last_cycle = active_reg && (baud_cnt_reg == BAUD_LAST) && (bit_cnt_reg == BIT_LAST);
  assign ready      = !active_reg || last_cycle;
  assign load       = valid && ready;
  assign tx         = tx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '1;
    end else if (load) begin
      active_reg   <= 1'b1;
      tx_reg       <= frame_bits[0];
      shift_reg    <= frame_bits[FRAME_MAX_BITS-1:1];
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
    end else if (active_reg) begin
      if (baud_cnt_reg == BAUD_LAST) begin
        baud_cnt_reg <= '0;
        if (bit_cnt_reg == BIT_LAST) begin
          active_reg  <= 1'b0;
          tx_reg      <= 1'b1;
          bit_cnt_reg <= '0;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
          tx_reg      <= shift_reg[0];
          shift_reg   <= {1'b1, shift_reg[FRAME_MAX_BITS-2:1]};
        end
      end else begin
        baud_cnt_reg <= baud_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_msg_tx.sv
// Message sequencer: sends a fixed string over UART one-shot or repeatedly with
// an idle gap, honouring a sticky abort that takes effect at frame boundaries.
module uart_msg_tx
  import uart_pkg::*;
#(
  parameter int                   CLK_HZ    = 50_000_000,
  parameter int                   BAUD      = 9600,
  parameter int                   DATA_BITS = 8,
  parameter int                   PARITY    = PARITY_NONE,
  parameter int                   STOP_BITS = 1,
  parameter int                   MSG_LEN   = 8,
  parameter logic [8*MSG_LEN-1:0] MSG       = "Hello!\r\n",
  parameter int                   GAP_BITS  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic repeat_en,
  input  logic abort,
  output logic tx,
  output logic busy,
  output logic char_strobe,
  output logic done
);

  localparam int DIV     = baud_div(CLK_HZ, BAUD);
  localparam int IW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int GAP_CYC = GAP_BITS * DIV;
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t        state_reg, state_next;
  logic [IW-1:0] index_reg, index_next, load_idx;
  logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
  logic          abort_reg, abort_next, abort_pend;
  logic          load, done_c;
  logic          frame_last, frame_ready;
  logic [7:0]    load_byte;
  logic [7:0]    msg_rom [MSG_LEN];

  // Character 0 is the leftmost (most significant) byte of the string literal.
  for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_rom
    assign msg_rom[gi] = MSG[8*(MSG_LEN-gi)-1 -: 8];
  end

  always_comb begin
    load_byte = msg_rom[0];
    for (int i = 1; i < MSG_LEN; i++) begin
      if (load_idx == IW'(i)) load_byte = msg_rom[i];
    end
  end

  always_comb begin
    state_next   = state_reg;
    index_next   = index_reg;
    gap_cnt_next = gap_cnt_reg;
    abort_next   = abort_reg;
    load         = 1'b0;
    load_idx     = '0;
    done_c       = 1'b0;
    abort_pend   = abort_reg | abort;
    case (state_reg)
      ST_IDLE: begin
        abort_next = 1'b0;
        if (start && !abort && frame_ready) begin
          state_next = ST_FRAME;
          index_next = '0;
          load       = 1'b1;
        end
      end
      ST_FRAME: begin
        if (abort) abort_next = 1'b1;
        if (frame_last) begin
          if (abort_pend) begin
            state_next = ST_IDLE;
            index_next = '0;
            abort_next = 1'b0;
          end else if (index_reg != LAST_IDX) begin
            index_next = index_reg + 1'b1;
            load_idx   = index_next;
            load       = 1'b1;
          end else begin
            done_c     = 1'b1;
            index_next = '0;
            if (!repeat_en) begin
              state_next = ST_IDLE;
            end else if (GAP_CYC == 0) begin
              load = 1'b1;
            end else begin
              state_next   = ST_GAP;
              gap_cnt_next = '0;
            end
          end
        end
      end
      ST_GAP: begin
        if (!repeat_en || abort) begin
          state_next = ST_IDLE;
        end else if (gap_cnt_reg == GAP_LAST) begin
          state_next   = ST_FRAME;
          gap_cnt_next = '0;
          load         = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      index_reg   <= '0;
      gap_cnt_reg <= '0;
      abort_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      index_reg   <= index_next;
      gap_cnt_reg <= gap_cnt_next;
      abort_reg   <= abort_next;
    end
  end

  uart_tx_frame #(
    .DIV      (DIV),
    .DATA_BITS(DATA_BITS),
    .PARITY   (PARITY),
    .STOP_BITS(STOP_BITS)
  ) u_frame (
    .clk       (clk),
    .rst       (rst),
    .data      (load_byte),
    .valid     (load),
    .ready     (frame_ready),
    .last_cycle(frame_last),
    .tx        (tx)
  );

  assign busy        = (state_reg != ST_IDLE);
  assign char_strobe = frame_last;
  assign done        = done_c;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Randomised bench for uart_msg_tx: three frame formats, each checked cycle by
// cycle against a waveform built from the frame rules.
module tb_uart_msg_tx;

  localparam int DIV = 10;
  localparam int NU  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NU-1:0] start = '0;
  logic [NU-1:0] repeat_en = '0;
  logic [NU-1:0] abort = '0;
  logic [NU-1:0] tx, busy, cs, done;

  int checks = 0;
  int passed = 0;

  // unit 0: 8N1 "ABC" gap 3; unit 1: 7O2 "aC" gap 0; unit 2: 8E2 "C" gap 1
  int cfg_db  [NU] = '{8, 7, 8};
  int cfg_par [NU] = '{0, 2, 1};
  int cfg_sb  [NU] = '{1, 2, 2};
  int cfg_gap [NU] = '{3, 0, 1};
  int cfg_len [NU] = '{3, 2, 1};
  logic [7:0] msg_tab [NU][3] = '{'{8'h41, 8'h42, 8'h43},
                                  '{8'h61, 8'h43, 8'h00},
                                  '{8'h43, 8'h00, 8'h00}};

  // expected per-cycle {tx, busy, char_strobe, done}
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  uart_msg_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .MSG_LEN(3), .MSG("ABC"), .GAP_BITS(3)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .repeat_en(repeat_en[0]), .abort(abort[0]),
    .tx(tx[0]), .busy(busy[0]), .char_strobe(cs[0]), .done(done[0]));

  uart_msg_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2), .MSG_LEN(2), .MSG("aC"), .GAP_BITS(0)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .repeat_en(repeat_en[1]), .abort(abort[1]),
    .tx(tx[1]), .busy(busy[1]), .char_strobe(cs[1]), .done(done[1]));

  uart_msg_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                .STOP_BITS(2), .MSG_LEN(1), .MSG("C"), .GAP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .repeat_en(repeat_en[2]), .abort(abort[2]),
    .tx(tx[2]), .busy(busy[2]), .char_strobe(cs[2]), .done(done[2]));

  function automatic int frame_cycles(int u);
    return DIV * (1 + cfg_db[u] + ((cfg_par[u] != 0) ? 1 : 0) + cfg_sb[u]);
  endfunction

  function automatic void push_const(int n, logic [3:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endfunction

  function automatic void push_frame(int u, logic [7:0] b, bit last);
    bit   bits[$];
    bit   p;
    logic fin;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < cfg_db[u]; i++) begin
      bits.push_back(b[i]);
      p = p ^ b[i];
    end
    if (cfg_par[u] == 2) p = ~p;
    if (cfg_par[u] != 0) bits.push_back(p);
    for (int i = 0; i < cfg_sb[u]; i++) bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++) begin
      for (int c = 0; c < DIV; c++) begin
        fin = (k == bits.size() - 1) && (c == DIV - 1);
        exp_q.push_back({bits[k], 1'b1, fin, fin & last});
      end
    end
  endfunction

  function automatic void push_msg(int u, int nframes, bit with_done);
    for (int i = 0; i < nframes; i++)
      push_frame(u, msg_tab[u][i], with_done && (i == cfg_len[u] - 1));
  endfunction

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    for (int u = 0; u < NU; u++) begin
      checks++; if (tx[u] !== 1'b1) $display("FAIL reset_tx u%0d: got %b expected 1", u, tx[u]); else passed++;
      checks++; if (busy[u] !== 1'b0) $display("FAIL reset_busy u%0d: got %b expected 0", u, busy[u]); else passed++;
      checks++; if (cs[u] !== 1'b0) $display("FAIL reset_strobe u%0d: got %b expected 0", u, cs[u]); else passed++;
      checks++; if (done[u] !== 1'b0) $display("FAIL reset_done u%0d: got %b expected 0", u, done[u]); else passed++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_oneshot(int u);
    int hold = $urandom_range(1, 20);
    int lead = $urandom_range(0, 7);
    int ndone = 0;
    logic [3:0] got;
    exp_q = {};
    push_msg(u, cfg_len[u], 1'b1);
    push_const(6, 4'b1000);
    repeat (lead + 1) @(negedge clk);
    start[u] = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      got = {tx[u], busy[u], cs[u], done[u]};
      checks++;
      if (got !== exp_q[i]) $display("FAIL oneshot u%0d cycle %0d: got tx/busy/strobe/done %b expected %b", u, i, got, exp_q[i]);
      else passed++;
      ndone += int'(done[u]);
      if (i == hold - 1) start[u] = 1'b0;
    end
    checks++;
    if (ndone != 1) $display("FAIL oneshot_done_count u%0d: got %0d expected 1", u, ndone); else passed++;
  endtask

  task automatic test_repeat(int u);
    int hold = $urandom_range(1, 20);
    int g = cfg_gap[u] * DIV;
    int l, cut, j;
    int ndone = 0;
    logic [3:0] got;
    exp_q = {};
    push_msg(u, cfg_len[u], 1'b1);
    l = exp_q.size();
    push_const(g, 4'b1100);
    push_msg(u, cfg_len[u], 1'b1);
    if (g > 0) begin
      j = $urandom_range(0, g - 1);
      push_const(j + 1, 4'b1100);
      cut = 2 * l + g + j;
    end else begin
      cut = 2 * l - 1;
    end
    push_const(6, 4'b1000);
    @(negedge clk);
    start[u] = 1'b1;
    repeat_en[u] = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      got = {tx[u], busy[u], cs[u], done[u]};
      checks++;
      if (got !== exp_q[i]) $display("FAIL repeat u%0d cycle %0d: got tx/busy/strobe/done %b expected %b", u, i, got, exp_q[i]);
      else passed++;
      ndone += int'(done[u]);
      if (i == hold - 1) start[u] = 1'b0;
      if (i == cut) repeat_en[u] = 1'b0;
    end
    checks++;
    if (ndone != 2) $display("FAIL repeat_done_count u%0d: got %0d expected 2", u, ndone); else passed++;
  endtask

  task automatic test_abort(int u);
    int k = $urandom_range(0, cfg_len[u] - 1);
    int e = k * frame_cycles(u) + $urandom_range(0, frame_cycles(u) - 1);
    int hold = $urandom_range(1, 20);
    int ndone = 0;
    logic [3:0] got;
    exp_q = {};
    push_msg(u, k + 1, 1'b0);
    push_const(6, 4'b1000);
    // start together with abort in idle must not launch anything
    @(negedge clk);
    start[u] = 1'b1;
    abort[u] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {tx[u], busy[u], cs[u], done[u]};
      checks++;
      if (got !== 4'b1000) $display("FAIL abort_blocks_start u%0d cycle %0d: got %b expected 1000", u, i, got);
      else passed++;
    end
    abort[u] = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      got = {tx[u], busy[u], cs[u], done[u]};
      checks++;
      if (got !== exp_q[i]) $display("FAIL abort u%0d cycle %0d (frame %0d): got tx/busy/strobe/done %b expected %b", u, i, k, got, exp_q[i]);
      else passed++;
      ndone += int'(done[u]);
      if (i == hold - 1) start[u] = 1'b0;
      abort[u] = (i == e);
    end
    abort[u] = 1'b0;
    checks++;
    if (ndone != 0) $display("FAIL abort_done_count u%0d: got %0d expected 0", u, ndone); else passed++;
  endtask

  task automatic test_abort_gap(int u);
    int g = cfg_gap[u] * DIV;
    int j = $urandom_range(0, g - 1);
    int l;
    logic [3:0] got;
    exp_q = {};
    push_msg(u, cfg_len[u], 1'b1);
    l = exp_q.size();
    push_const(j + 1, 4'b1100);
    push_const(6, 4'b1000);
    @(negedge clk);
    start[u] = 1'b1;
    repeat_en[u] = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      got = {tx[u], busy[u], cs[u], done[u]};
      checks++;
      if (got !== exp_q[i]) $display("FAIL abort_gap u%0d cycle %0d: got tx/busy/strobe/done %b expected %b", u, i, got, exp_q[i]);
      else passed++;
      if (i == 3) start[u] = 1'b0;
      abort[u] = (i == l + j);
    end
    abort[u] = 1'b0;
    repeat_en[u] = 1'b0;
  endtask

  task automatic test_start_held(int u);
    int l;
    int drop;
    int ndone = 0;
    logic [3:0] got;
    exp_q = {};
    push_msg(u, cfg_len[u], 1'b1);
    l = exp_q.size();
    push_const(1, 4'b1000);
    push_msg(u, cfg_len[u], 1'b1);
    push_const(6, 4'b1000);
    drop = l + 1 + $urandom_range(0, 20);
    @(negedge clk);
    start[u] = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      got = {tx[u], busy[u], cs[u], done[u]};
      checks++;
      if (got !== exp_q[i]) $display("FAIL start_held u%0d cycle %0d: got tx/busy/strobe/done %b expected %b", u, i, got, exp_q[i]);
      else passed++;
      ndone += int'(done[u]);
      if (i == drop) start[u] = 1'b0;
    end
    checks++;
    if (ndone != 2) $display("FAIL start_held_done_count u%0d: got %0d expected 2", u, ndone); else passed++;
  endtask

  task automatic test_reset_midframe(int u);
    int r = $urandom_range(0, DIV - 2);
    int hold = $urandom_range(1, 20);
    logic [3:0] got;
    exp_q = {};
    push_msg(u, cfg_len[u], 1'b1);
    push_const(6, 4'b1000);
    @(negedge clk);
    start[u] = 1'b1;
    for (int i = 0; i <= r; i++) begin
      @(negedge clk);
      got = {tx[u], busy[u], cs[u], done[u]};
      checks++;
      if (got !== exp_q[i]) $display("FAIL pre_reset u%0d cycle %0d: got %b expected %b", u, i, got, exp_q[i]);
      else passed++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx[u] !== 1'b1) $display("FAIL async_reset_tx u%0d: got %b expected 1", u, tx[u]); else passed++;
    checks++;
    if (busy[u] !== 1'b0) $display("FAIL async_reset_busy u%0d: got %b expected 0", u, busy[u]); else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      got = {tx[u], busy[u], cs[u], done[u]};
      checks++;
      if (got !== exp_q[i]) $display("FAIL post_reset u%0d cycle %0d: got tx/busy/strobe/done %b expected %b", u, i, got, exp_q[i]);
      else passed++;
      if (i == hold - 1) start[u] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    for (int u = 0; u < NU; u++) begin
      test_oneshot(u);
      test_oneshot(u);
      test_repeat(u);
      test_abort(u);
      test_abort(u);
    end
    test_abort_gap(0);
    test_abort_gap(2);
    test_start_held(0);
    test_start_held(1);
    test_reset_midframe(0);
    test_reset_midframe(1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_msg_tx.md
Name: uart_msg_tx

Overview:
Parametrised successor to the fixed-character transmit demo. It sends a compile-time message string of MSG_LEN bytes over a UART line. Frame format (data bits, parity, stop bits) and baud rate are configurable. A message runs one-shot on a start pulse, or repeats continuously with an idle gap between repetitions. It sits at board top level as a self-contained console/beacon source and drives the FPGA TX pin directly.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BAUD, 9600, line rate; DIV = round(CLK_HZ/BAUD) clocks per bit, DIV >= 2
DATA_BITS, 8, data bits per frame, 5..8; low DATA_BITS of each message byte are sent
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
MSG_LEN, 8, number of bytes in message, >= 1
MSG, "Hello!\r\n", packed 8*MSG_LEN string; byte index 0 = MSG[8*MSG_LEN-1 -: 8] (first character written)
GAP_BITS, 16, idle bit-times (tx=1) between repetitions in repeat mode, >= 0

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  level-sampled; in IDLE, high starts a message
repeat_en  in  1  sampled at end of each message; 1 = gap then resend
abort  in  1  request to stop after the current frame
tx  out  1  serial line, idle high, registered
busy  out  1  high from first start-bit cycle through last stop/gap cycle
char_strobe  out  1  one-cycle pulse on last cycle of each frame's final stop bit
done  out  1  one-cycle pulse on last cycle of final frame of a message (not on abort)

Behaviour:
- Reset (async): tx=1, busy=0, char_strobe=0, done=0, state IDLE, index=0, all counters 0. Reset mid-frame drops tx to 1 immediately.
- States: IDLE -> FRAME -> (FRAME | GAP | IDLE); GAP -> FRAME | IDLE.
- IDLE: start=1 and abort=0 at edge k -> FRAME, index=0, tx=0 (start bit) and busy=1 from edge k+1. start=1 with abort=1 -> stay IDLE.
- FRAME: bit sequence = start(0), DATA_BITS LSB first, parity if PARITY!=0 (even: XOR of data bits; odd: its inverse), STOP_BITS ones. Each bit is held exactly DIV cycles. Frame length = DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles. Next frame's start bit follows with no extra idle cycle.
- End of frame, last cycle: char_strobe=1. If index<MSG_LEN-1 and no abort pending, index++ and next FRAME. If index==MSG_LEN-1: done=1, index wraps to 0; repeat_en=1 -> GAP (or FRAME directly if GAP_BITS=0), else IDLE.
- GAP: tx=1, busy=1 for GAP_BITS*DIV cycles, then FRAME at index 0. If repeat_en=0 at any GAP cycle -> IDLE next edge.
- abort: latched (sticky) while busy. The current frame completes, including stop bits. Then IDLE, no done pulse, latch cleared. abort during GAP -> IDLE next edge.
- start while busy is ignored. start held high in IDLE after a one-shot message restarts it on the cycle after busy falls.
- Counter widths: baud counter $clog2(DIV); bit counter $clog2(12); index max(1,$clog2(MSG_LEN)); gap counter sized for GAP_BITS*DIV. All counters wrap only by explicit reload, with no overflow.

Decomposition:
- Package uart_pkg: PARITY_NONE/EVEN/ODD constants, state enum, function baud_div(clk_hz, baud) with rounding.
- Sub-module uart_tx_frame: serializer with valid/ready handshake (data, valid in; ready, last_cycle, tx out) and the same frame parameters. uart_msg_tx holds the sequencer FSM, index, gap counter and abort latch.

Test Plan:
- CLK_HZ=1e6, BAUD=1e5 (DIV=10), 8N1, MSG="AB", start pulse at cycle 0 -> tx low from cycle 1. Frame 'A' (0x41) bits 0,1,0,0,0,0,0,1,0,1 each 10 cycles. 'B' follows immediately. done pulses once at cycle 200. busy=0 from cycle 201.
- PARITY=1, STOP_BITS=2, MSG="C" (0x43) -> parity bit 1. Frame is 12 bit-times (120 cycles). char_strobe and done coincide.
- repeat_en=1, GAP_BITS=3, MSG="A" -> tx high for exactly 30 cycles between frames; done pulses every 130 cycles.
- abort asserted mid-data of char 0 of "ABC" -> char 0 completes, tx stays high, no char 1, done never pulses, busy falls after stop bit.
- rst asserted mid-frame while tx=0 -> tx=1 asynchronously. After release with start=1, message restarts at index 0.
- DATA_BITS=7, PARITY=2, MSG="a" (0x61) -> 7 data bits 1,0,0,0,0,1,1, odd parity bit 0, frame 100 cycles.
